// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 restoring divider for MIPS DIV/DIVU in the
//               execute stage. Returns {hi=remainder, lo=quotient} and holds
//               stallE while a divide is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startE,
  input  logic               signedE,
  input  logic               cancelE,
  input  logic [WIDTH-1:0]   aE,
  input  logic [WIDTH-1:0]   bE,
  output logic               stallE,
  output logic               readyE,
  output logic [2*WIDTH-1:0] resultE
);

  localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_div  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_dvs;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_start;
  logic                 w_b_zero;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_trial;
  logic                 w_bit;
  logic [WIDTH-1:0]     w_rem_next;
  logic [WIDTH-1:0]     w_quo_next;
  logic [WIDTH-1:0]     w_q_fix;
  logic [WIDTH-1:0]     w_r_fix;
  logic                 w_last;

  // Request qualification and operand magnitudes for the signed form
  assign w_start  = startE & ~cancelE;
  assign w_b_zero = (bE == '0);
  assign w_a_neg  = signedE & aE[WIDTH-1];
  assign w_b_neg  = signedE & bE[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -aE : aE;
  assign w_b_mag  = w_b_neg ? -bE : bE;

  // One restoring step: shift in the next dividend bit, try the subtract.
  // r_quo starts as the dividend magnitude and is shifted out MSB first while
  // the quotient bits fill in from the bottom.
  assign w_trial    = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
  assign w_bit      = ~w_trial[WIDTH];
  assign w_rem_next = w_bit ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_quo_next = {r_quo[WIDTH-2:0], w_bit};
  assign w_last     = (r_cnt == c_cnt_last);

  // Sign correction applied to the final step's values as they are stored
  assign w_q_fix = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_fix = r_neg_r ? -w_rem_next : w_rem_next;

  assign resultE = r_result;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: cancel beats start in IDLE and aborts in DIV; DONE always exits
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_start) begin
          w_next_state = w_b_zero ? c_st_done : c_st_div;
        end
      end
      c_st_div: begin
        if (cancelE) begin
          w_next_state = c_st_idle;
        end else if (w_last) begin
          w_next_state = c_st_done;
        end
      end
      c_st_done: w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // Outputs: stall covers the accepting cycle and DIV, ready pulses in DONE
  always_comb begin
    stallE = 1'b0;
    readyE = 1'b0;
    case (r_state)
      c_st_idle: stallE = w_start;
      c_st_div:  stallE = 1'b1;
      c_st_done: readyE = 1'b1;
      default: begin
        stallE = 1'b0;
        readyE = 1'b0;
      end
    endcase
  end

  // Datapath: latch operands on accept, iterate in DIV, publish on DONE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_start) begin
            if (w_b_zero) begin
              r_result <= {aE, {WIDTH{1'b1}}};
            end else begin
              r_cnt   <= '0;
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_dvs   <= w_b_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end
          end
        end
        c_st_div: begin
          if (!cancelE) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + c_cnt_one;
            if (w_last) begin
              r_result <= {w_r_fix, w_q_fix};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit: vector table plus directed
//               cancel / reset / DONE-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           startE;
  logic           signedE;
  logic           cancelE;
  logic [W-1:0]   aE;
  logic [W-1:0]   bE;
  logic           stallE;
  logic           readyE;
  logic [2*W-1:0] resultE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] exp;   // {remainder, quotient}
    int             lat;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .startE  (startE),
    .signedE (signedE),
    .cancelE (cancelE),
    .aE      (aE),
    .bE      (bE),
    .stallE  (stallE),
    .readyE  (readyE),
    .resultE (resultE)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_no_ready(input string name, input int n);
    int bad = 0;
    repeat (n) begin
      if (readyE) bad++;
      step();
    end
    check(name, 64'(bad), 64'd0);
  endtask

  // Issue one divide and follow it to the readyE pulse
  task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input logic [2*W-1:0] exp, input int lat,
                         input bit poke_done);
    int cyc = 0;
    int st  = 0;
    aE = a; bE = b; signedE = sgn; startE = 1'b1; cancelE = 1'b0;
    #1;
    while (!readyE && cyc < 100) begin
      if (stallE) st++;
      step();
      startE  = 1'b0;
      aE      = $urandom;
      bE      = $urandom;
      signedE = 1'($urandom);
      cyc++;
      #1;
    end
    check({name, " latency"}, 64'(cyc), 64'(lat));
    check({name, " stall cycles"}, 64'(st), 64'(lat));
    check({name, " ready"}, 64'(readyE), 64'd1);
    check({name, " stall in done"}, 64'(stallE), 64'd0);
    check({name, " result"}, resultE, exp);
    if (poke_done) begin
      startE  = 1'b1;
      cancelE = 1'b1;
      #1;
      check({name, " ready with cancel in done"}, 64'(readyE), 64'd1);
      check({name, " stall with start in done"}, 64'(stallE), 64'd0);
    end
    step();
    startE  = 1'b0;
    cancelE = 1'b0;
    #1;
    check({name, " pulse width"}, 64'(readyE), 64'd0);
    check({name, " result held"}, resultE, exp);
  endtask

  initial begin
    vecs[0]  = '{32'd100,       32'd7,         1'b0, {32'd2,         32'd14},        33};
    vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, {32'hFFFFFFFF,  32'hFFFFFFFD},  33};
    vecs[2]  = '{32'd7,         32'hFFFFFFFE,  1'b1, {32'h00000001,  32'hFFFFFFFD},  33};
    vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, {32'h00000000,  32'h80000000},  33};
    vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, {32'h80000000,  32'h00000000},  33};
    vecs[5]  = '{32'hFFFFFFFF,  32'd1,         1'b0, {32'h00000000,  32'hFFFFFFFF},  33};
    vecs[6]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, {32'hFFFFFFFE,  32'h0000000E},  33};
    vecs[7]  = '{32'd5,         32'd10,        1'b0, {32'd5,         32'd0},         33};
    vecs[8]  = '{32'hDEADBEEF,  32'h10,        1'b0, {32'h0000000F,  32'h0DEADBEE},  33};
    vecs[9]  = '{32'd1000,      32'hFFFFFFFD,  1'b1, {32'h00000001,  32'hFFFFFEB3},  33};
    vecs[10] = '{32'h12345678,  32'd0,         1'b0, {32'h12345678,  32'hFFFFFFFF},  1};
    vecs[11] = '{32'hFFFFFFFB,  32'd0,         1'b1, {32'hFFFFFFFB,  32'hFFFFFFFF},  1};

    rst = 1'b1; startE = 1'b0; signedE = 1'b0; cancelE = 1'b0; aE = '0; bE = '0;
    step();
    step();
    check("reset result", resultE, 64'd0);
    check("reset ready", 64'(readyE), 64'd0);
    check("reset stall", 64'(stallE), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
              vecs[i].exp, vecs[i].lat, 1'b0);
      step();
    end

    // Cancel at iteration 10 keeps the previous result
    run_div("prior", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 1'b0);
    aE = 32'd1000; bE = 32'd3; signedE = 1'b0; startE = 1'b1;
    step();
    startE = 1'b0;
    repeat (9) step();
    cancelE = 1'b1;
    step();
    cancelE = 1'b0;
    #1;
    check("cancel stall drops", 64'(stallE), 64'd0);
    wait_no_ready("cancel no pulse", 40);
    check("cancel result kept", resultE, {32'd2, 32'd14});
    run_div("after cancel 9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 1'b1);
    wait_no_ready("start in done ignored", 40);

    // Cancel beats start in IDLE
    aE = 32'd9; bE = 32'd3; startE = 1'b1; cancelE = 1'b1;
    #1;
    check("cancel vs start stall", 64'(stallE), 64'd0);
    step();
    startE = 1'b0; cancelE = 1'b0;
    #1;
    check("cancel vs start idle", 64'(stallE), 64'd0);
    wait_no_ready("cancel vs start no pulse", 40);

    // Asynchronous reset at iteration 20
    aE = 32'd77; bE = 32'd5; signedE = 1'b0; startE = 1'b1;
    step();
    startE = 1'b0;
    repeat (19) step();
    #2;
    rst = 1'b1;
    #1;
    check("midreset result", resultE, 64'd0);
    check("midreset ready", 64'(readyE), 64'd0);
    check("midreset stall", 64'(stallE), 64'd0);
    step();
    step();
    rst = 1'b0;
    wait_no_ready("midreset no pulse", 40);
    run_div("after reset 50/5", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
